// File: rtl/spi_master_engine_if.sv
// rtl/spi_master_engine_if.sv - command/response handshake bundle between the OBI slave and spi_master_engine
interface spi_master_engine_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic [DATA_WIDTH-1:0] cmd_data_i;
  logic                  cmd_last_i;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [DATA_WIDTH-1:0] rsp_data_o;

  modport master (
    output cmd_valid_i, cmd_data_i, cmd_last_i, rsp_ready_i,
    input  cmd_ready_o, rsp_valid_o, rsp_data_o
  );

  modport slave (
    input  cmd_valid_i, cmd_data_i, cmd_last_i, rsp_ready_i,
    output cmd_ready_o, rsp_valid_o, rsp_data_o
  );
endinterface

// File: rtl/spi_master_engine.sv
// rtl/spi_master_engine.sv - mode-0 MSB-first SPI master fed by command words, single-entry response slot
// Optional feature: SPI_LOOPBACK_EN adds loopback_i, sampling spi_mosi_o instead of spi_miso_i.
module spi_master_engine #(
  parameter int DATA_WIDTH     = 8,
  parameter int CLK_DIV        = 4,
  parameter int CS_IDLE_CYCLES = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  spi_master_engine_if.slave  bus,
  output logic                busy_o,
  output logic                spi_sck_o,
  output logic                spi_cs_no,
  output logic                spi_mosi_o,
`ifdef SPI_LOOPBACK_EN
  input  logic                loopback_i,
`endif
  input  logic                spi_miso_i
);
  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int BIT_W = $clog2(2 * DATA_WIDTH + 1);
  localparam int GAP_W = $clog2(CS_IDLE_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, WAIT_NEXT, GAP} state_t;

  state_t                state, state_next;
  logic [DIV_W-1:0]      div_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [GAP_W-1:0]      gap_cnt;
  logic [DATA_WIDTH-1:0] tx_sh;
  logic [DATA_WIDTH-1:0] rx_sh;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_valid;
  logic                  last_q;
  logic                  sck;
  logic                  cs_n;
  logic                  cmd_ready;
  logic                  accept;
  logic                  toggle;
  logic                  last_edge;
  logic                  sample;

  assign accept    = bus.cmd_valid_i && cmd_ready;
  assign toggle    = (state == SHIFT) && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign last_edge = toggle && (bit_cnt == BIT_W'(2 * DATA_WIDTH - 1));

`ifdef SPI_LOOPBACK_EN
  assign sample = loopback_i ? tx_sh[DATA_WIDTH-1] : spi_miso_i;
`else
  assign sample = spi_miso_i;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, WAIT_NEXT: if (accept) state_next = SETUP;
      SETUP:           if (div_cnt == DIV_W'(CLK_DIV)) state_next = SHIFT;
      SHIFT:           if (last_edge) state_next = last_q ? GAP : WAIT_NEXT;
      GAP:             if (gap_cnt == GAP_W'(CS_IDLE_CYCLES - 1)) state_next = IDLE;
      default:         state_next = IDLE;
    endcase
  end

  // The response slot must be free (or emptying this cycle) so an unread rx word is never overwritten.
  always_comb begin
    cmd_ready = 1'b0;
    busy_o    = (state != IDLE);
    if (!rst_i && (state == IDLE || state == WAIT_NEXT) && (!rsp_valid || bus.rsp_ready_i))
      cmd_ready = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_cnt  <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      last_q   <= 1'b0;
      sck      <= 1'b0;
      cs_n     <= 1'b1;
    end else begin
      cs_n <= !(state_next == SETUP || state_next == SHIFT || state_next == WAIT_NEXT);
      case (state)
        SETUP: div_cnt <= (state_next == SHIFT) ? '0 : div_cnt + DIV_W'(1);
        SHIFT: begin
          if (toggle) begin
            div_cnt <= '0;
            bit_cnt <= bit_cnt + BIT_W'(1);
            sck     <= !sck;
            if (!sck)
              rx_sh <= {rx_sh[DATA_WIDTH-2:0], sample};
            else if (!last_edge)
              tx_sh <= {tx_sh[DATA_WIDTH-2:0], 1'b0};
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        GAP:     gap_cnt <= gap_cnt + GAP_W'(1);
        default: ;
      endcase
      if (accept) begin
        tx_sh   <= bus.cmd_data_i;
        last_q  <= bus.cmd_last_i;
        div_cnt <= '0;
        bit_cnt <= '0;
        rx_sh   <= '0;
      end
      if (state_next == GAP && state != GAP)
        gap_cnt <= '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else if (last_edge) begin
      rsp_valid <= 1'b1;
      rsp_data  <= rx_sh;
    end else if (rsp_valid && bus.rsp_ready_i) begin
      rsp_valid <= 1'b0;
    end
  end

  assign bus.cmd_ready_o = cmd_ready;
  assign bus.rsp_valid_o = rsp_valid;
  assign bus.rsp_data_o  = rsp_data;
  assign spi_sck_o       = sck;
  assign spi_cs_no       = cs_n;
  assign spi_mosi_o      = tx_sh[DATA_WIDTH-1];
endmodule

// File: tb/tb_spi_master_engine.sv
// tb/tb_spi_master_engine.sv - directed bench for spi_master_engine with a mode-0 SPI target model
module tb_spi_master_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_master_engine_if #(.DATA_WIDTH(8)) b ();
  spi_master_engine_if #(.DATA_WIDTH(8)) b1 ();

  logic busy, sck, cs_n, mosi, miso;
  logic busy1, sck1, cs1_n, mosi1;
  logic lb_on = 1'b0;

  spi_master_engine #(.DATA_WIDTH(8), .CLK_DIV(2), .CS_IDLE_CYCLES(2)) dut (
    .clk_i(clk), .rst_i(rst), .bus(b), .busy_o(busy),
    .spi_sck_o(sck), .spi_cs_no(cs_n), .spi_mosi_o(mosi),
`ifdef SPI_LOOPBACK_EN
    .loopback_i(lb_on),
`endif
    .spi_miso_i(miso)
  );

  spi_master_engine #(.DATA_WIDTH(8), .CLK_DIV(1), .CS_IDLE_CYCLES(2)) dut1 (
    .clk_i(clk), .rst_i(rst), .bus(b1), .busy_o(busy1),
    .spi_sck_o(sck1), .spi_cs_no(cs1_n), .spi_mosi_o(mosi1),
`ifdef SPI_LOOPBACK_EN
    .loopback_i(1'b0),
`endif
    .spi_miso_i(1'b1)
  );

  // Mode-0 target: presents tgt_word MSB first, advances on each SCK fall, wraps every 8 bits.
  logic [7:0] tgt_word = 8'h00;
  logic [2:0] fcnt;
  logic [7:0] mosi_cap = 8'h00;
  int         rises = 0;
  int         cs_rises = 0;

  always @(negedge sck or posedge cs_n) begin
    if (cs_n) fcnt <= 3'd0;
    else      fcnt <= fcnt + 3'd1;
  end
  always @(posedge sck) begin
    rises    <= rises + 1;
    mosi_cap <= {mosi_cap[6:0], mosi};
  end
  always @(posedge cs_n) cs_rises <= cs_rises + 1;
  assign miso = lb_on ? 1'b0 : tgt_word[3'd7 - fcnt];

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  // Caller is positioned at a negedge; returns at the negedge where rsp_valid_o is first seen.
  task automatic send_word(input logic [7:0] d, input logic l, output int lat);
    int n;
    b.cmd_data_i  = d;
    b.cmd_last_i  = l;
    b.cmd_valid_i = 1'b1;
    n = 0;
    while (!b.cmd_ready_o && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("accept_timeout", 32'd1, 32'd0);
    @(negedge clk);
    b.cmd_valid_i = 1'b0;
    lat = 0;
    while (!b.rsp_valid_o && lat < 400) begin @(negedge clk); lat++; end
  endtask

  task automatic check_gap(input string tag);
    chk({tag, "_gap0_cs"}, cs_n, 1'b1);
    chk({tag, "_gap0_rdy"}, b.cmd_ready_o, 1'b0);
    @(negedge clk);
    chk({tag, "_gap1_cs"}, cs_n, 1'b1);
    chk({tag, "_gap1_rdy"}, b.cmd_ready_o, 1'b0);
    @(negedge clk);
    chk({tag, "_idle_rdy"}, b.cmd_ready_o, 1'b1);
  endtask

  typedef struct {
    logic [7:0] d;
    logic [7:0] tgt;
    logic [7:0] exp_rx;
    logic [7:0] exp_mosi;
    int         exp_lat;
  } vec_t;

  initial begin
    vec_t vecs[4];
    int   lat, r0, c0, n, tog;
    logic prev;

    vecs[0] = '{8'hA5, 8'h3C, 8'h3C, 8'hA5, 35};
    vecs[1] = '{8'h00, 8'hFF, 8'hFF, 8'h00, 35};
    vecs[2] = '{8'hFF, 8'h00, 8'h00, 8'hFF, 35};
    vecs[3] = '{8'h81, 8'h7E, 8'h7E, 8'h81, 35};

    b.cmd_valid_i = 1'b0; b.cmd_data_i = 8'h00; b.cmd_last_i = 1'b0; b.rsp_ready_i = 1'b1;
    b1.cmd_valid_i = 1'b0; b1.cmd_data_i = 8'h00; b1.cmd_last_i = 1'b0; b1.rsp_ready_i = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_sck", sck, 1'b0);
    chk("rst_cs", cs_n, 1'b1);
    chk("rst_mosi", mosi, 1'b0);
    chk("rst_rsp_valid", b.rsp_valid_o, 1'b0);
    chk("rst_rsp_data", b.rsp_data_o, 8'h00);
    chk("rst_cmd_ready", b.cmd_ready_o, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      tgt_word = vecs[i].tgt;
      send_word(vecs[i].d, 1'b1, lat);
      chk($sformatf("v%0d_rsp", i), b.rsp_data_o, vecs[i].exp_rx);
      chk($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
      chk($sformatf("v%0d_mosi", i), mosi_cap, vecs[i].exp_mosi);
      check_gap($sformatf("v%0d", i));
    end

    // Two-word frame with CS held low across WAIT_NEXT
    tgt_word = 8'h96; r0 = rises; c0 = cs_rises;
    send_word(8'h01, 1'b0, lat);
    chk("fr_w1_rsp", b.rsp_data_o, 8'h96);
    chk("fr_w1_lat", lat, 35);
    chk("fr_w1_mosi", mosi_cap, 8'h01);
    chk("fr_wait_cs", cs_n, 1'b0);
    chk("fr_wait_sck", sck, 1'b0);
    chk("fr_wait_mosi", mosi, 1'b1);
    chk("fr_wait_rdy", b.cmd_ready_o, 1'b1);
    send_word(8'hFF, 1'b1, lat);
    chk("fr_w2_rsp", b.rsp_data_o, 8'h96);
    chk("fr_w2_lat", lat, 35);
    chk("fr_w2_mosi", mosi_cap, 8'hFF);
    chk("fr_rises", rises - r0, 16);
    chk("fr_cs_rises", cs_rises - c0, 1);
    check_gap("fr");

    // Response backpressure holds off the next command
    b.rsp_ready_i = 1'b0; tgt_word = 8'h3C;
    send_word(8'h5A, 1'b0, lat);
    chk("bp_w1_lat", lat, 35);
    b.cmd_data_i = 8'hC0; b.cmd_last_i = 1'b1; b.cmd_valid_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("bp_rdy%0d", k), b.cmd_ready_o, 1'b0);
      chk($sformatf("bp_valid%0d", k), b.rsp_valid_o, 1'b1);
      chk($sformatf("bp_data%0d", k), b.rsp_data_o, 8'h3C);
    end
    b.rsp_ready_i = 1'b1;
    #1;
    chk("bp_rdy_release", b.cmd_ready_o, 1'b1);
    @(negedge clk);
    b.cmd_valid_i = 1'b0;
    tgt_word = 8'h81;
    chk("bp_acc_valid", b.rsp_valid_o, 1'b0);
    chk("bp_acc_cs", cs_n, 1'b0);
    chk("bp_acc_busy", busy, 1'b1);
    lat = 0;
    while (!b.rsp_valid_o && lat < 400) begin @(negedge clk); lat++; end
    chk("bp_w2_lat", lat, 35);
    chk("bp_w2_rsp", b.rsp_data_o, 8'h81);
    chk("bp_w2_mosi", mosi_cap, 8'hC0);
    check_gap("bp");

    // Asynchronous reset at SCK rise 4
    tgt_word = 8'h3C;
    b.cmd_data_i = 8'h5A; b.cmd_last_i = 1'b1; b.cmd_valid_i = 1'b1;
    @(negedge clk);
    b.cmd_valid_i = 1'b0;
    r0 = rises; n = 0;
    while ((rises - r0) < 4 && n < 1000) begin #1; n++; end
    chk("ar_reached_rise4", rises - r0, 4);
    rst = 1'b1;
    #1;
    chk("ar_cs", cs_n, 1'b1);
    chk("ar_sck", sck, 1'b0);
    chk("ar_rsp_valid", b.rsp_valid_o, 1'b0);
    chk("ar_busy", busy, 1'b0);
    chk("ar_rdy", b.cmd_ready_o, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ar_post_valid", b.rsp_valid_o, 1'b0);
    chk("ar_post_rdy", b.cmd_ready_o, 1'b1);
    tgt_word = 8'hA3;
    send_word(8'h55, 1'b1, lat);
    chk("ar_w_lat", lat, 35);
    chk("ar_w_rsp", b.rsp_data_o, 8'hA3);
    chk("ar_w_mosi", mosi_cap, 8'h55);
    check_gap("ar");

    // CLK_DIV=1 instance, target MISO tied high
    b1.cmd_data_i = 8'h80; b1.cmd_last_i = 1'b1; b1.cmd_valid_i = 1'b1;
    chk("d1_rdy", b1.cmd_ready_o, 1'b1);
    @(negedge clk);
    b1.cmd_valid_i = 1'b0;
    lat = 0; tog = 0; prev = sck1;
    while (!b1.rsp_valid_o && lat < 200) begin
      @(negedge clk); lat++;
      if (sck1 != prev && lat >= 3 && lat <= 18) tog++;
      prev = sck1;
    end
    chk("d1_lat", lat, 18);
    chk("d1_toggles", tog, 16);
    chk("d1_rsp", b1.rsp_data_o, 8'hFF);
    chk("d1_mosi_last", mosi1, 1'b0);
    repeat (3) @(negedge clk);

`ifdef SPI_LOOPBACK_EN
    lb_on = 1'b1;
    send_word(8'hC3, 1'b1, lat);
    chk("lb_rsp", b.rsp_data_o, 8'hC3);
    chk("lb_lat", lat, 35);
    check_gap("lb");
    lb_on = 1'b0;
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/spi_master_engine.md
Name: spi_master_engine

Overview:
- Downstream stage of the OBI slave: consumes command words the OBI slave has decoded from bus writes and drives a single SPI target as mode-0 master (CPOL=0, CPHA=0), MSB first.
- Each command carries one data word to shift out and a flag that ends the chip-select frame.
- The received word is returned through a single-entry response register, which the OBI slave reads back via rdata/rvalid.

Parameters:
- DATA_WIDTH, 8, bits per SPI word; must be ≥2.
- CLK_DIV, 4, clk_i cycles per SCK half-period; must be ≥1.
- CS_IDLE_CYCLES, 2, minimum clk_i cycles CS stays deasserted between frames; must be ≥1.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous reset, active-high
- cmd_valid_i  in  1  command word available
- cmd_ready_o  out  1  engine accepts command this cycle
- cmd_data_i  in  DATA_WIDTH  word to transmit
- cmd_last_i  in  1  deassert CS after this word
- rsp_valid_o  out  1  received word available
- rsp_ready_i  in  1  consumer takes received word
- rsp_data_o  out  DATA_WIDTH  received word
- busy_o  out  1  high whenever state ≠ IDLE
- spi_sck_o  out  1  SPI clock
- spi_cs_no  out  1  chip select, active-low
- spi_mosi_o  out  1  master out
- spi_miso_i  in  1  master in (no synchroniser; target runs on SCK)

Behaviour:
- Reset (async, while rst_i high): state=IDLE, spi_sck_o=0, spi_cs_no=1, spi_mosi_o=0, rsp_valid_o=0, rsp_data_o=0, cmd_ready_o=0, busy_o=0. Counters and shift registers are cleared.
- Reset mid-frame: CS rises immediately. The partial word and any pending response are discarded.
- Handshakes: transfer occurs when valid&ready are high on the same rising edge.
  - cmd_ready_o is combinational: 1 in IDLE or WAIT_NEXT when (!rsp_valid_o || rsp_ready_i), else 0.
  - rsp_valid_o, once high, holds with stable rsp_data_o until rsp_ready_i is seen.
- States:
  - IDLE: CS high, SCK low. Accepting a command latches data/last, drives CS low and MOSI=data[MSB] on the same edge → SETUP.
  - SETUP: hold CLK_DIV cycles (CS-to-first-edge setup) → SHIFT.
  - SHIFT: SCK toggles every CLK_DIV cycles, 2*DATA_WIDTH half-periods in total.
    - Each rising edge samples spi_miso_i into the rx shift register (LSB in).
    - Each falling edge except the last drives the next MOSI bit.
    - On the edge that drives the final SCK fall, rsp_data_o is loaded with the rx word and rsp_valid_o is set. Then → GAP if last, else WAIT_NEXT.
  - WAIT_NEXT: CS stays low, SCK low, MOSI holds. Acceptance of the next command loads MOSI=data[MSB] → SETUP. No timeout.
  - GAP: CS high for exactly CS_IDLE_CYCLES cycles, cmd_ready_o=0 → IDLE.
- Latency: word time from accept to rsp_valid_o = 1 + CLK_DIV + 2*DATA_WIDTH*CLK_DIV cycles. Example: CLK_DIV=2, DATA_WIDTH=8 gives 35 cycles.
- Response backpressure: if the previous response is still pending, cmd_ready_o stays low, so an unread rx word is never overwritten. SCK never stalls mid-word.
- A new response can never be produced while rsp_valid_o is high, because command acceptance already requires the response slot to be free.
- Counters: the half-period counter is $clog2(CLK_DIV+1) bits and the bit counter is $clog2(2*DATA_WIDTH+1) bits. Both reload from zero and never wrap mid-word.

Optional Feature:
- Macro: SPI_LOOPBACK_EN.
- Defined: adds input port loopback_i (1 bit). While loopback_i=1, rising-edge sampling takes spi_mosi_o instead of spi_miso_i, so rsp_data_o equals the transmitted word. loopback_i must be stable for a whole frame; a change mid-frame takes effect at the next sample.
- Undefined: port is absent; sampling is always from spi_miso_i.

Test Plan (CLK_DIV=2, DATA_WIDTH=8, CS_IDLE_CYCLES=2):
- Single word: cmd 0xA5 with last=1, target returns 0x3C.
  - MOSI bits 1,0,1,0,0,1,0,1 stable across each SCK rise.
  - rsp_data_o=0x3C, rsp_valid_o 35 cycles after accept.
  - CS high 2 cycles, then cmd_ready_o=1.
- Two-word frame: 0x01 with last=0, then 0xFF with last=1 presented immediately. CS stays low between words, SCK idles low in WAIT_NEXT, 16 SCK rising edges total.
- Backpressure: rsp_ready_i=0 after word 1 of a last=0 frame, with cmd_valid_i=1. cmd_ready_o stays 0 and rsp_data_o is held. Raising rsp_ready_i → command accepted on that same cycle.
- Async reset asserted at SCK rise 4 of 8. spi_cs_no=1 and spi_sck_o=0 without waiting for a clock edge; rsp_valid_o stays 0. After release, 0x55 transfers correctly.
- CLK_DIV=1 corner: cmd 0x80 with last=1. SCK toggles every cycle, rsp_valid_o 18 cycles after accept.
- SPI_LOOPBACK_EN defined, loopback_i=1, cmd 0xC3 with spi_miso_i tied to 0 → rsp_data_o=0xC3.
